// File: rtl/rx_frame_derand_if.sv
// Serial receive bus between an upstream demodulator/decoder and rx_frame_derand.
// master = bit source (drives EnI side), slave = rx_frame_derand.
interface rx_frame_derand_if;
  // EnI and EnO are valid strobes with no ready: a bit is consumed on every cycle
  // EnI=1, and every cycle EnO=1 carries a DataO the sink must take in that cycle.
  logic EnI;
  logic DataI;
  logic Block_ErrI;
  logic IP_END;
  logic Bypass;
  logic DataO;
  logic EnO;
  logic SyncO;
  logic FrameEndO;
  logic Block_ErrO;
  logic IP_END_O;

  modport master (
    output EnI, DataI, Block_ErrI, IP_END, Bypass,
    input  DataO, EnO, SyncO, FrameEndO, Block_ErrO, IP_END_O
  );

  modport slave (
    input  EnI, DataI, Block_ErrI, IP_END, Bypass,
    output DataO, EnO, SyncO, FrameEndO, Block_ErrO, IP_END_O
  );
endinterface

// File: rtl/rx_frame_derand.sv
// Serial frame sync-hunt and PN derandomizer: finds SYNC_WORD, then descrambles FRAME_LEN bits.
// Optional statistics counters (SyncCntO/ErrCntO) are built when RX_FRAME_DERAND_STATS_EN is defined.
module rx_frame_derand #(
  parameter int                SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hEB90,
  parameter int                MAX_ERR   = 0,
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'h5F,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hFF,
  parameter int                FRAME_LEN = 1024
) (
  input  logic               Clk,
  input  logic               Rst,
  rx_frame_derand_if.slave   bus,
  output logic               dbg_state
`ifdef RX_FRAME_DERAND_STATS_EN
  ,
  output logic [15:0]        SyncCntO,
  output logic [15:0]        ErrCntO
`endif
);

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  state_t            state;
  logic [SYNC_W-1:0] shreg;
  logic [SYNC_W-1:0] shreg_next;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [15:0]       bit_cnt;

  logic data_q;
  logic en_q;
  logic sync_q;
  logic fend_q;
  logic blk_err_q;
  logic ip_end_q;

  int   mism;
  logic match;
  logic accept;
  logic sync_hit;
  logic data_hit;
  logic last_bit;

  assign shreg_next = {shreg[SYNC_W-2:0], bus.DataI};
  assign lfsr_next  = {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};

  // Hamming distance of the candidate window (after this bit shifts in) to the marker
  always_comb begin
    mism = 0;
    for (int i = 0; i < SYNC_W; i++) begin
      mism = mism + int'(shreg_next[i] ^ SYNC_WORD[i]);
    end
  end

  assign match    = (mism <= MAX_ERR);
  assign accept   = bus.EnI && !bus.Block_ErrI && !bus.IP_END;
  assign sync_hit = accept && (state == HUNT) && match;
  assign data_hit = accept && (state == DATA);
  assign last_bit = (bit_cnt == LAST_IDX);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= HUNT;
      shreg     <= '0;
      lfsr      <= LFSR_SEED;
      bit_cnt   <= '0;
      data_q    <= 1'b0;
      en_q      <= 1'b0;
      sync_q    <= 1'b0;
      fend_q    <= 1'b0;
      blk_err_q <= 1'b0;
      ip_end_q  <= 1'b0;
    end else begin
      blk_err_q <= bus.Block_ErrI;
      ip_end_q  <= bus.IP_END;
      data_q    <= 1'b0;
      en_q      <= 1'b0;
      sync_q    <= 1'b0;
      fend_q    <= 1'b0;

      if (bus.Block_ErrI) begin
        state   <= HUNT;
        shreg   <= '0;
        lfsr    <= LFSR_SEED;
        bit_cnt <= '0;
      end else if (bus.IP_END) begin
        // the bit presented alongside IP_END is dropped, not shifted or output
        state   <= HUNT;
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (state == HUNT) begin
        if (bus.EnI) begin
          shreg <= shreg_next;
        end
        if (sync_hit) begin
          state   <= DATA;
          lfsr    <= LFSR_SEED;
          bit_cnt <= '0;
          sync_q  <= 1'b1;
        end
      end else if (data_hit) begin
        en_q   <= 1'b1;
        data_q <= bus.Bypass ? bus.DataI : (bus.DataI ^ lfsr[0]);
        lfsr   <= lfsr_next;
        if (last_bit) begin
          fend_q  <= 1'b1;
          state   <= HUNT;
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.DataO      = data_q;
  assign bus.EnO        = en_q;
  assign bus.SyncO      = sync_q;
  assign bus.FrameEndO  = fend_q;
  assign bus.Block_ErrO = blk_err_q;
  assign bus.IP_END_O   = ip_end_q;
  assign dbg_state      = (state == DATA);

`ifdef RX_FRAME_DERAND_STATS_EN
  logic [15:0] sync_cnt;
  logic [15:0] err_cnt;

  // blk_err_q holds the previous Block_ErrI, so this counts rising edges only
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (sync_hit && (sync_cnt != 16'hFFFF)) begin
        sync_cnt <= sync_cnt + 16'd1;
      end
      if (bus.Block_ErrI && !blk_err_q && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign SyncCntO = sync_cnt;
  assign ErrCntO  = err_cnt;
`endif

endmodule

// File: tb/tb_rx_frame_derand.sv
// Bench for rx_frame_derand: a default instance and a MAX_ERR=1/FRAME_LEN=4 instance share stimulus.
module tb_rx_frame_derand;
  localparam logic [15:0] SYNC = 16'hEB90;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rx_frame_derand_if bus_a ();
  rx_frame_derand_if bus_b ();
  logic dbg_a;
  logic dbg_b;
`ifdef RX_FRAME_DERAND_STATS_EN
  logic [15:0] sc_a, ec_a, sc_b, ec_b;
`endif

  rx_frame_derand u_a (
    .Clk(clk), .Rst(rst), .bus(bus_a), .dbg_state(dbg_a)
`ifdef RX_FRAME_DERAND_STATS_EN
    , .SyncCntO(sc_a), .ErrCntO(ec_a)
`endif
  );

  rx_frame_derand #(.MAX_ERR(1), .FRAME_LEN(4)) u_b (
    .Clk(clk), .Rst(rst), .bus(bus_b), .dbg_state(dbg_b)
`ifdef RX_FRAME_DERAND_STATS_EN
    , .SyncCntO(sc_b), .ErrCntO(ec_b)
`endif
  );

  typedef struct packed {
    logic       en;
    logic       d;
    logic [6:0] exp;  // {DataO, EnO, SyncO, FrameEndO, Block_ErrO, IP_END_O, state}
  } vec_t;

  // reference model state, index 0 = u_a, 1 = u_b
  bit          pn [1024];
  bit          m_in_data [2];
  logic [15:0] m_hist [2];
  int          m_idx [2];
  int          m_sync_cnt [2];
  int          m_err_cnt;
  bit          m_prev_be;
  logic [13:0] exp_q [$];

  logic [6:0] last_a, last_b;
  int n_sync_a, n_sync_b, n_fend_b, n_en_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int c, input logic r, en, d, be, ie, byp,
                            output logic [6:0] o);
    int   flen;
    int   maxe;
    logic od, oen, osync, ofend;
    flen  = (c == 0) ? 1024 : 4;
    maxe  = (c == 0) ? 0 : 1;
    od    = 1'b0;
    oen   = 1'b0;
    osync = 1'b0;
    ofend = 1'b0;
    if (!r) begin
      m_in_data[c]  = 1'b0;
      m_hist[c]     = '0;
      m_idx[c]      = 0;
      m_sync_cnt[c] = 0;
    end else if (be || ie) begin
      m_in_data[c] = 1'b0;
      m_hist[c]    = '0;
      m_idx[c]     = 0;
    end else if (en) begin
      if (!m_in_data[c]) begin
        m_hist[c] = {m_hist[c][14:0], d};
        if ($countones(m_hist[c] ^ SYNC) <= maxe) begin
          m_in_data[c] = 1'b1;
          m_idx[c]     = 0;
          osync        = 1'b1;
          if (m_sync_cnt[c] < 65535) m_sync_cnt[c]++;
        end
      end else begin
        oen = 1'b1;
        od  = byp ? d : (d ^ pn[m_idx[c]]);
        if (m_idx[c] == flen - 1) begin
          ofend        = 1'b1;
          m_in_data[c] = 1'b0;
          m_hist[c]    = '0;
          m_idx[c]     = 0;
        end else begin
          m_idx[c]++;
        end
      end
    end
    o = {od, oen, osync, ofend, r & be, r & ie, m_in_data[c]};
  endtask

  task automatic tick(input logic r, en, d, be, ie, byp);
    logic [6:0]  ea, eb;
    logic [13:0] e;
    rst              = r;
    bus_a.EnI        = en;  bus_b.EnI        = en;
    bus_a.DataI      = d;   bus_b.DataI      = d;
    bus_a.Block_ErrI = be;  bus_b.Block_ErrI = be;
    bus_a.IP_END     = ie;  bus_b.IP_END     = ie;
    bus_a.Bypass     = byp; bus_b.Bypass     = byp;
    model_step(0, r, en, d, be, ie, byp, ea);
    model_step(1, r, en, d, be, ie, byp, eb);
    if (!r) m_err_cnt = 0;
    else if (be && !m_prev_be && m_err_cnt < 65535) m_err_cnt++;
    m_prev_be = r & be;
    exp_q.push_back({ea, eb});
    @(posedge clk);
    #1;
    last_a = {bus_a.DataO, bus_a.EnO, bus_a.SyncO, bus_a.FrameEndO,
              bus_a.Block_ErrO, bus_a.IP_END_O, dbg_a};
    last_b = {bus_b.DataO, bus_b.EnO, bus_b.SyncO, bus_b.FrameEndO,
              bus_b.Block_ErrO, bus_b.IP_END_O, dbg_b};
    e = exp_q.pop_front();
    chk("model_a", 32'(last_a), 32'(e[13:7]));
    chk("model_b", 32'(last_b), 32'(e[6:0]));
    n_sync_a += int'(last_a[4]);
    n_sync_b += int'(last_b[4]);
    n_fend_b += int'(last_b[3]);
    n_en_a   += int'(last_a[5]);
  endtask

  task automatic clr_cnt();
    n_sync_a = 0;
    n_sync_b = 0;
    n_fend_b = 0;
    n_en_a   = 0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) tick(1'b1, 1'b1, w[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      tick(1'b1, 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    clr_cnt();
  endtask

  initial begin
    vec_t        vt [25];
    logic [15:0] sw;
    logic [8:0]  pn9;
    logic [7:0]  lf;
    logic [15:0] w;
    int          k;

    // first 9 PN bits for seed FF / taps 5F, first received bit in pn9[8]
    sw  = SYNC;
    pn9 = 9'b111111110;
    for (int i = 0; i < 25; i++) begin
      vt[i].en  = 1'b1;
      vt[i].d   = (i < 16) ? sw[15-i] : 1'b0;
      vt[i].exp = '0;
      if (i == 15) vt[i].exp = 7'b0010001;
      if (i >= 16) vt[i].exp = {pn9[8-(i-16)], 6'b100001};
    end

    lf = 8'hFF;
    for (int i = 0; i < 1024; i++) begin
      pn[i] = lf[0];
      lf    = {^(lf & 8'h5F), lf[7:1]};
    end
    for (int c = 0; c < 2; c++) begin
      m_in_data[c]  = 1'b0;
      m_hist[c]     = '0;
      m_idx[c]      = 0;
      m_sync_cnt[c] = 0;
    end
    m_err_cnt = 0;
    m_prev_be = 1'b0;
    clr_cnt();

    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_a", 32'(last_a), 32'd0);
    chk("reset_b", 32'(last_b), 32'd0);

    // sync EB90 then zeros: SyncO one cycle after last sync bit, then PN bits
    for (int i = 0; i < 25; i++) begin
      tick(1'b1, vt[i].en, vt[i].d, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d", i), 32'(last_a), 32'(vt[i].exp));
    end

    // one-bit error accepted only with MAX_ERR=1; two-bit error rejected
    flush();
    send_word(16'hEB91);
    chk("eb91_sync_b", n_sync_b, 1);
    chk("eb91_sync_a", n_sync_a, 0);
    flush();
    send_word(16'hEB93);
    chk("eb93_sync_b", n_sync_b, 0);
    chk("eb93_state_b", 32'(last_b[0]), 32'd0);

    // back-to-back short frames; second sync is plain data on the long-frame instance
    flush();
    send_word(SYNC);
    send_bits(4, 1'b1);
    send_word(SYNC);
    send_bits(4, 1'b1);
    chk("b2b_sync_b", n_sync_b, 2);
    chk("b2b_fend_b", n_fend_b, 2);
    chk("b2b_sync_a", n_sync_a, 1);

    // block error on data bit 3 aborts the frame
    flush();
    send_word(SYNC);
    send_bits(2, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("berr_eno", 32'(last_a[5]), 32'd0);
    chk("berr_out", 32'(last_a[2]), 32'd1);
    chk("berr_state", 32'(last_a[0]), 32'd0);
    clr_cnt();
    send_bits(6, 1'b1);
    chk("berr_no_data", n_en_a, 0);

    // IP_END mid-frame discards the bit and returns to hunt
    flush();
    send_word(SYNC);
    send_bits(2, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ipend_eno", 32'(last_a[5]), 32'd0);
    chk("ipend_out", 32'(last_a[1]), 32'd1);
    chk("ipend_state", 32'(last_a[0]), 32'd0);

    // gapped EnI with alternating bypass
    flush();
    send_word(SYNC);
    clr_cnt();
    for (int i = 0; i < 8; i++)
      tick(1'b1, 1'((i % 2) == 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'((i % 4) == 0));
    chk("gap_en_count", n_en_a, 4);

    // reset mid-frame
    flush();
    send_word(SYNC);
    send_bits(3, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_a", 32'(last_a), 32'd0);
    chk("midrst_b", 32'(last_b), 32'd0);
    clr_cnt();
    send_bits(10, 1'b0);
    chk("midrst_no_data", n_en_a, 0);
    send_word(SYNC);
    chk("midrst_resync", n_sync_a, 1);

    // randomized frames with marker errors, EnI gaps, aborts and resets
    for (int f = 0; f < 60; f++) begin
      k = $urandom_range(0, 8);
      for (int i = 0; i < k; i++)
        tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      w = SYNC;
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) w[$urandom_range(0, 15)] ^= 1'b1;
      for (int i = 15; i >= 0; i--) begin
        if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, w[i], 1'b0, 1'b0, 1'b0);
      end
      k = $urandom_range(1, 40);
      for (int i = 0; i < k; i++)
        tick(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0),
             1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

`ifdef RX_FRAME_DERAND_STATS_EN
    chk("sync_cnt_a", 32'(sc_a), 32'(m_sync_cnt[0]));
    chk("sync_cnt_b", 32'(sc_b), 32'(m_sync_cnt[1]));
    chk("err_cnt_a", 32'(ec_a), 32'(m_err_cnt));
    chk("err_cnt_b", 32'(ec_b), 32'(m_err_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
